// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared axis-state encoding and standard VGA timing sets.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    typedef enum logic [1:0] {
        AX_ACTIVE = 2'd0,
        AX_FRONT  = 2'd1,
        AX_SYNC   = 2'd2,
        AX_BACK   = 2'd3
    } axis_state_t;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33
    };

    localparam vga_timing_t VGA_800x600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
    };

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis: wrapping position counter plus
//               ACTIVE->FRONT->SYNC->BACK phase FSM, advancing on step.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int CNT_W  = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output axis_state_t      state,
    output logic             wrap
);

    localparam int c_total = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [CNT_W-1:0] c_last_active = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] c_last_front  = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] c_last_sync   = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] c_last        = CNT_W'(c_total - 1);

    generate
        if (ACTIVE < 1 || FP < 1 || BP < 1 || SYNC < 0) begin : g_bad_timing
            $error("vga_axis_counter: ACTIVE, FP and BP must be non-zero, SYNC non-negative");
        end
        if (c_total > (1 << CNT_W)) begin : g_bad_width
            $error("vga_axis_counter: CNT_W too narrow for the axis total");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    axis_state_t      r_state;
    axis_state_t      w_state_next;
    logic             w_at_last;

    assign w_at_last = (r_cnt == c_last);
    assign wrap      = step && w_at_last;
    assign cnt       = r_cnt;
    assign state     = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_state <= AX_ACTIVE;
        end else if (step) begin
            r_cnt   <= w_at_last ? '0 : r_cnt + CNT_W'(1);
            r_state <= w_state_next;
        end
    end

    // A zero-width sync skips straight from the front porch to the back porch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            AX_ACTIVE: if (r_cnt == c_last_active) w_state_next = AX_FRONT;
            AX_FRONT:  if (r_cnt == c_last_front)  w_state_next = (SYNC > 0) ? AX_SYNC : AX_BACK;
            AX_SYNC:   if (r_cnt == c_last_sync)   w_state_next = AX_BACK;
            AX_BACK:   if (w_at_last)              w_state_next = AX_ACTIVE;
            default:                               w_state_next = AX_ACTIVE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator with pixel enable
//               and a registered, phase-aligned colour output stage.
// Options     : VGA_TEST_PATTERN_EN adds input tp_en and an 8-bar colour source.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_640x480_60.h_active,
    parameter int   H_FP     = VGA_640x480_60.h_fp,
    parameter int   H_SYNC   = VGA_640x480_60.h_sync,
    parameter int   H_BP     = VGA_640x480_60.h_bp,
    parameter int   V_ACTIVE = VGA_640x480_60.v_active,
    parameter int   V_FP     = VGA_640x480_60.v_fp,
    parameter int   V_SYNC   = VGA_640x480_60.v_sync,
    parameter int   V_BP     = VGA_640x480_60.v_bp,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   CW       = 4,
    parameter int   CNT_W    = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_ce,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             tp_en,
`endif
    input  logic [3*CW-1:0]  rgb_in,
    output logic [CNT_W-1:0] req_x,
    output logic [CNT_W-1:0] req_y,
    output logic             req_valid,
    output logic             hsync,
    output logic             vsync,
    output logic             active_video,
    output logic [CW-1:0]    red,
    output logic [CW-1:0]    green,
    output logic [CW-1:0]    blue,
    output logic             line_start,
    output logic             frame_start
);

    generate
        if (CW < 1) begin : g_bad_cw
            $error("vga_timing_gen: CW must be at least 1");
        end
    endgenerate

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    axis_state_t      w_h_state;
    axis_state_t      w_v_state;
    logic             w_h_wrap;
    logic             w_unused_v_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CNT_W  (CNT_W)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (pix_ce),
        .cnt    (w_h_cnt),
        .state  (w_h_state),
        .wrap   (w_h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CNT_W  (CNT_W)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (pix_ce & w_h_wrap),
        .cnt    (w_v_cnt),
        .state  (w_v_state),
        .wrap   (w_unused_v_wrap)
    );

    // Stage-0 decode of the pixel currently being requested.
    logic            w_active;
    logic            w_hsync;
    logic            w_vsync;
    logic            w_line0;
    logic            w_frame0;
    logic [3*CW-1:0] w_rgb_src;

    assign w_active  = (w_h_state == AX_ACTIVE) && (w_v_state == AX_ACTIVE);
    assign w_hsync   = (w_h_state == AX_SYNC) ? H_POL : ~H_POL;
    assign w_vsync   = (w_v_state == AX_SYNC) ? V_POL : ~V_POL;
    assign w_line0   = (w_h_cnt == '0);
    assign w_frame0  = w_line0 && (w_v_cnt == '0);

    assign req_x     = w_h_cnt;
    assign req_y     = w_v_cnt;
    assign req_valid = w_active;

`ifdef VGA_TEST_PATTERN_EN
    localparam int c_bar_w = H_ACTIVE / 8;

    generate
        if (c_bar_w < 1) begin : g_bad_bar
            $error("vga_timing_gen: H_ACTIVE too small for 8 colour bars");
        end
    endgenerate

    logic [CNT_W-1:0] r_bar_px;
    logic [2:0]       r_bar_idx;

    // Bar index tracks req_x; it saturates at bar 7 through the blanking interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
        end else if (pix_ce) begin
            if (w_h_wrap) begin
                r_bar_px  <= '0;
                r_bar_idx <= '0;
            end else if (r_bar_px == CNT_W'(c_bar_w - 1)) begin
                r_bar_px <= '0;
                if (r_bar_idx != 3'd7) begin
                    r_bar_idx <= r_bar_idx + 3'd1;
                end
            end else begin
                r_bar_px <= r_bar_px + CNT_W'(1);
            end
        end
    end

    assign w_rgb_src = tp_en ? {{CW{~r_bar_idx[2]}}, {CW{~r_bar_idx[1]}}, {CW{~r_bar_idx[0]}}}
                             : rgb_in;
`else
    assign w_rgb_src = rgb_in;
`endif

    logic            r_hsync;
    logic            r_vsync;
    logic            r_active;
    logic            r_line_start;
    logic            r_frame_start;
    logic [3*CW-1:0] r_rgb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync       <= ~H_POL;
            r_vsync       <= ~V_POL;
            r_active      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_rgb         <= '0;
        end else if (pix_ce) begin
            r_hsync       <= w_hsync;
            r_vsync       <= w_vsync;
            r_active      <= w_active;
            r_line_start  <= w_line0;
            r_frame_start <= w_frame0;
            r_rgb         <= w_active ? w_rgb_src : '0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign active_video = r_active;
    assign line_start   = r_line_start;
    assign frame_start  = r_frame_start;
    assign red          = r_rgb[3*CW-1:2*CW];
    assign green        = r_rgb[2*CW-1:CW];
    assign blue         = r_rgb[CW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed bench for vga_timing_gen: a reduced-size raster
//               instance (24x11 total) and an 800x600 positive-sync instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
    localparam int HT = 24, VT = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_ce = 1'b0;
    logic rgb_mode = 1'b0;
    logic tp_en = 1'b0;
    logic [11:0] rgb_in_a;

    logic [10:0] req_x_a, req_y_a, req_x_b, req_y_b;
    logic        req_valid_a, hsync_a, vsync_a, active_video_a, line_start_a, frame_start_a;
    logic        req_valid_b, hsync_b, vsync_b, active_video_b, line_start_b, frame_start_b;
    logic [3:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    always_comb rgb_in_a = rgb_mode ? 12'hA5C : {3{req_x_a[3:0]}};

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0), .CW(4), .CNT_W(11)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
`ifdef VGA_TEST_PATTERN_EN
        .tp_en(tp_en),
`endif
        .rgb_in(rgb_in_a), .req_x(req_x_a), .req_y(req_y_a), .req_valid(req_valid_a),
        .hsync(hsync_a), .vsync(vsync_a), .active_video(active_video_a),
        .red(red_a), .green(green_a), .blue(blue_a),
        .line_start(line_start_a), .frame_start(frame_start_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1),  .V_SYNC(4),   .V_BP(23),
        .H_POL(1'b1), .V_POL(1'b1), .CW(4), .CNT_W(11)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
`ifdef VGA_TEST_PATTERN_EN
        .tp_en(1'b0),
`endif
        .rgb_in(12'h123), .req_x(req_x_b), .req_y(req_y_b), .req_valid(req_valid_b),
        .hsync(hsync_b), .vsync(vsync_b), .active_video(active_video_b),
        .red(red_b), .green(green_b), .blue(blue_b),
        .line_start(line_start_b), .frame_start(frame_start_b)
    );

    // Expected stage-1 outputs {hs,vs,av,ls,fs,rgb} for stage-0 pixel (px,py).
    function automatic logic [16:0] exp_s1(input int px, input int py, input logic tp);
        logic        vis;
        logic [2:0]  k;
        logic [3:0]  xl;
        logic [11:0] rgb;
        vis = (px < HA) && (py < VA);
        k   = 3'(px / 2);
        xl  = 4'(px);
        if (!vis)          rgb = 12'h000;
        else if (tp)       rgb = {{4{~k[2]}}, {4{~k[1]}}, {4{~k[0]}}};
        else if (rgb_mode) rgb = 12'hA5C;
        else               rgb = {xl, xl, xl};
        return {!(px >= 18 && px <= 20), !(py >= 7 && py <= 8), vis, px == 0, px == 0 && py == 0, rgb};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic ce);
        rst_n  = 1'b0;
        pix_ce = ce;
        step();
        rst_n  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pix_ce = 1'b1; rgb_mode = 1'b0;
        repeat (3) step();
        total++; if ({req_x_a, req_y_a} !== 22'd0) begin bad++; $display("FAIL reset_req got=%h/%h want=0/0", req_x_a, req_y_a); end
        total++; if (req_valid_a !== 1'b1) begin bad++; $display("FAIL reset_valid got=%b want=1", req_valid_a); end
        total++; if ({hsync_a, vsync_a} !== 2'b11) begin bad++; $display("FAIL reset_sync_a got=%b want=11", {hsync_a, vsync_a}); end
        total++; if ({active_video_a, line_start_a, frame_start_a} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {active_video_a, line_start_a, frame_start_a}); end
        total++; if ({red_a, green_a, blue_a} !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h want=000", {red_a, green_a, blue_a}); end
        total++; if ({hsync_b, vsync_b} !== 2'b00) begin bad++; $display("FAIL reset_sync_b got=%b want=00", {hsync_b, vsync_b}); end
    endtask

    task automatic test_raster();
        int mx, my, fs0, fs1, hs_lo, vs_lo, ls_n, av_n;
        logic [16:0] ex;
        restart(1'b1);
        mx = 0; my = 0; fs0 = -1; fs1 = -1; hs_lo = 0; vs_lo = 0; ls_n = 0; av_n = 0;
        for (int i = 0; i < 2 * HT * VT + 4; i++) begin
            ex = exp_s1(mx, my, 1'b0);
            mx++;
            if (mx == HT) begin mx = 0; my++; if (my == VT) my = 0; end
            step();
            total++;
            if ({req_x_a, req_y_a, req_valid_a, hsync_a, vsync_a, active_video_a, line_start_a, frame_start_a, red_a, green_a, blue_a}
                !== {11'(mx), 11'(my), (mx < HA && my < VA), ex}) begin
                bad++;
                $display("FAIL raster i=%0d got x=%0d y=%0d v=%b s1=%h want x=%0d y=%0d s1=%h", i, req_x_a, req_y_a, req_valid_a,
                         {hsync_a, vsync_a, active_video_a, line_start_a, frame_start_a, red_a, green_a, blue_a}, mx, my, ex);
            end
            if (i < HT * VT) begin
                hs_lo += (hsync_a == 1'b0) ? 1 : 0;
                vs_lo += (vsync_a == 1'b0) ? 1 : 0;
                ls_n  += line_start_a ? 1 : 0;
                av_n  += active_video_a ? 1 : 0;
            end
            if (frame_start_a) begin if (fs0 < 0) fs0 = i; else if (fs1 < 0) fs1 = i; end
        end
        total++; if (fs1 - fs0 !== 264) begin bad++; $display("FAIL frame_period got=%0d want=264", fs1 - fs0); end
        total++; if (hs_lo !== 33) begin bad++; $display("FAIL hsync_low_count got=%0d want=33", hs_lo); end
        total++; if (vs_lo !== 48) begin bad++; $display("FAIL vsync_low_count got=%0d want=48", vs_lo); end
        total++; if (ls_n !== 11) begin bad++; $display("FAIL line_start_count got=%0d want=11", ls_n); end
        total++; if (av_n !== 96) begin bad++; $display("FAIL active_count got=%0d want=96", av_n); end
    endtask

    task automatic test_ce_div4();
        int mx, my, fs0, fs1, fs_n;
        logic [16:0] ex, prev;
        restart(1'b0);
        mx = 0; my = 0; fs0 = -1; fs1 = -1; fs_n = 0;
        prev = {1'b1, 1'b1, 3'b000, 12'h000};
        for (int i = 0; i < 4 * HT * VT + 8; i++) begin
            pix_ce = (i % 4 == 0);
            if (pix_ce) begin
                ex = exp_s1(mx, my, 1'b0);
                mx++;
                if (mx == HT) begin mx = 0; my++; if (my == VT) my = 0; end
            end else begin
                ex = {prev[16:14], 2'b00, prev[11:0]};
            end
            step();
            total++;
            if ({req_x_a, req_y_a, hsync_a, vsync_a, active_video_a, line_start_a, frame_start_a, red_a, green_a, blue_a}
                !== {11'(mx), 11'(my), ex}) begin
                bad++;
                $display("FAIL ce_div4 i=%0d got x=%0d y=%0d s1=%h want x=%0d y=%0d s1=%h", i, req_x_a, req_y_a,
                         {hsync_a, vsync_a, active_video_a, line_start_a, frame_start_a, red_a, green_a, blue_a}, mx, my, ex);
            end
            prev = ex;
            if (frame_start_a) begin
                fs_n++;
                if (fs0 < 0) fs0 = i; else if (fs1 < 0) fs1 = i;
            end
        end
        pix_ce = 1'b1;
        total++; if (fs1 - fs0 !== 1056) begin bad++; $display("FAIL ce_frame_period got=%0d want=1056", fs1 - fs0); end
        total++; if (fs_n !== 2) begin bad++; $display("FAIL ce_frame_pulses got=%0d want=2", fs_n); end
    endtask

    task automatic test_rgb();
        logic found;
        restart(1'b1);
        rgb_mode = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin step(); if (req_x_a == 11'd5) found = 1'b1; end
        total++; if (!found) begin bad++; $display("FAIL rgb_wait_x5 got=timeout want=x5"); end
        step();
        total++; if ({red_a, green_a, blue_a} !== 12'h555) begin bad++; $display("FAIL rgb_x5 got=%h want=555", {red_a, green_a, blue_a}); end
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin step(); if (req_x_a == 11'd17) found = 1'b1; end
        total++; if ({found, active_video_a, red_a, green_a, blue_a} !== {1'b1, 1'b0, 12'h000}) begin
            bad++; $display("FAIL rgb_blank got=%b/%b/%h want=1/0/000", found, active_video_a, {red_a, green_a, blue_a});
        end
        rgb_mode = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin step(); if (req_x_a == 11'd3 && req_y_a == 11'd1) found = 1'b1; end
        total++; if ({found, red_a, green_a, blue_a} !== {1'b1, 12'hA5C}) begin
            bad++; $display("FAIL rgb_const got=%b/%h want=1/a5c", found, {red_a, green_a, blue_a});
        end
        rgb_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic found;
        restart(1'b1);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin step(); if (req_x_a == 11'd10 && req_y_a == 11'd4) found = 1'b1; end
        total++; if (!found) begin bad++; $display("FAIL mid_wait got=timeout want=(10,4)"); end
        rst_n = 1'b0;
        #1;
        total++; if ({req_x_a, req_y_a, req_valid_a, hsync_a, vsync_a, active_video_a, line_start_a, frame_start_a, red_a, green_a, blue_a}
                     !== {22'd0, 1'b1, 2'b11, 3'b000, 12'h000}) begin
            bad++; $display("FAIL mid_async got x=%0d y=%0d rgb=%h av=%b want 0/0/000/0", req_x_a, req_y_a, {red_a, green_a, blue_a}, active_video_a);
        end
        repeat (3) step();
        rst_n = 1'b1;
        total++; if ({req_x_a, req_y_a} !== 22'd0) begin bad++; $display("FAIL mid_release got=%0d/%0d want=0/0", req_x_a, req_y_a); end
        step();
        total++; if ({req_x_a, frame_start_a, line_start_a} !== {11'd1, 2'b11}) begin
            bad++; $display("FAIL mid_restart got x=%0d fs=%b ls=%b want x=1 fs=1 ls=1", req_x_a, frame_start_a, line_start_a);
        end
    endtask

    task automatic test_800x600();
        int hs_n, hs_first, hs_last, vs_n, wrap_at;
        restart(1'b1);
        hs_n = 0; hs_first = -1; hs_last = -1; vs_n = 0; wrap_at = -1;
        for (int i = 0; i < 1056; i++) begin
            step();
            if (hsync_b) begin hs_n++; if (hs_first < 0) hs_first = i; hs_last = i; end
            if (vsync_b) vs_n++;
            if (req_x_b == 11'd0 && wrap_at < 0) wrap_at = i;
        end
        total++; if (wrap_at !== 1055) begin bad++; $display("FAIL b_htotal got=%0d want=1055", wrap_at); end
        total++; if (req_y_b !== 11'd1) begin bad++; $display("FAIL b_line_inc got=%0d want=1", req_y_b); end
        total++; if (hs_n !== 128) begin bad++; $display("FAIL b_hsync_width got=%0d want=128", hs_n); end
        total++; if ({hs_first, hs_last} !== {32'sd840, 32'sd967}) begin bad++; $display("FAIL b_hsync_window got=%0d..%0d want=840..967", hs_first, hs_last); end
        total++; if (vs_n !== 0) begin bad++; $display("FAIL b_vsync_idle got=%0d want=0", vs_n); end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        int mx, my;
        logic [16:0] ex;
        restart(1'b1);
        rgb_mode = 1'b0;
        mx = 0; my = 0;
        for (int i = 0; i < 3 * HT; i++) begin
            tp_en = (i < 2 * HT);
            ex = exp_s1(mx, my, tp_en);
            mx++;
            if (mx == HT) begin mx = 0; my++; end
            step();
            total++;
            if ({active_video_a, red_a, green_a, blue_a} !== {ex[14], ex[11:0]}) begin
                bad++; $display("FAIL pattern i=%0d tp=%b got=%b/%h want=%b/%h", i, tp_en, active_video_a, {red_a, green_a, blue_a}, ex[14], ex[11:0]);
            end
        end
        tp_en = 1'b0;
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_raster();
        test_ce_div4();
        test_rgb();
        test_reset_mid();
        test_800x600();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
